// File: rtl/ssd1306_spi_decoder.sv
// ssd1306_spi_decoder: SSD1306-style SPI front end for the Arduboy display path.
// The block deserializes the SPI byte stream, decodes display commands and turns
// data bytes into addressed writes to the 8-page x 128-column framebuffer.
// Optional macro OLED_CMD_DECODE_EN enables full command decoding. Without it,
// every command byte only homes the pointer, and the status outputs are tied.
module ssd1306_spi_decoder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       oled_sck,
  input  logic       oled_mosi,
  input  logic       oled_dc,
  input  logic       oled_cs_n,
  output logic       fb_we,
  output logic [9:0] fb_addr,
  output logic [7:0] fb_data,
  output logic       frame_done,
  output logic       display_on,
  output logic       invert,
  output logic [7:0] contrast
);

  typedef enum logic [1:0] {
    MODE_HORIZ = 2'b00,
    MODE_VERT  = 2'b01,
    MODE_PAGE  = 2'b10
  } addr_mode_e;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] dc_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   sck_d;
  logic                   sck_s;
  logic                   mosi_s;
  logic                   dc_s;
  logic                   cs_s;
  logic                   sck_rise;

  logic [6:0] shift_reg;
  logic [2:0] bit_cnt;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_dc;

  logic [6:0] col_ptr;
  logic [2:0] page_ptr;
  logic [6:0] col_nx;
  logic [2:0] page_nx;
  logic       we_nx;
  logic [9:0] addr_nx;
  logic [7:0] data_nx;
  logic       done_nx;

  addr_mode_e mode_q;
  logic [6:0] col_start_q;
  logic [6:0] col_end_q;
  logic [2:0] page_start_q;
  logic [2:0] page_end_q;

`ifdef OLED_CMD_DECODE_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ARG1 = 2'b01,
    S_ARG2 = 2'b10
  } cmd_state_e;

  cmd_state_e state_q;
  cmd_state_e state_nx;
  logic [7:0] opcode_q;
  logic [7:0] opcode_nx;
  addr_mode_e mode_nx;
  logic [6:0] col_start_nx;
  logic [6:0] col_end_nx;
  logic [2:0] page_start_nx;
  logic [2:0] page_end_nx;
  logic       disp_q;
  logic       disp_nx;
  logic       inv_q;
  logic       inv_nx;
  logic [7:0] contrast_q;
  logic [7:0] contrast_nx;

  assign display_on = disp_q;
  assign invert     = inv_q;
  assign contrast   = contrast_q;
`else
  assign mode_q       = MODE_HORIZ;
  assign col_start_q  = 7'd0;
  assign col_end_q    = 7'd127;
  assign page_start_q = 3'd0;
  assign page_end_q   = 3'd7;
  assign display_on   = 1'b1;
  assign invert       = 1'b0;
  assign contrast     = 8'h7F;
`endif

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign dc_s     = dc_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;

  // Synchronize the asynchronous SPI pins; sck_d gives the edge-detect history
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      dc_sync   <= '0;
      cs_sync   <= '1;
      sck_d     <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], oled_sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], oled_mosi};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0], oled_dc};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], oled_cs_n};
      sck_d     <= sck_s;
    end
  end

  // Shift in MSB-first bits; a deselect drops any partial byte
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      byte_dc    <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (cs_s) begin
        bit_cnt <= '0;
      end else if (sck_rise) begin
        shift_reg <= {shift_reg[5:0], mosi_s};
        bit_cnt   <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_valid <= 1'b1;
          byte_data  <= {shift_reg, mosi_s};
          byte_dc    <= dc_s;
        end
      end
    end
  end

  // Decode cycle: data bytes become writes plus a pointer advance, commands update state
  always_comb begin
    col_nx  = col_ptr;
    page_nx = page_ptr;
    we_nx   = 1'b0;
    addr_nx = fb_addr;
    data_nx = fb_data;
    done_nx = 1'b0;
`ifdef OLED_CMD_DECODE_EN
    state_nx      = state_q;
    opcode_nx     = opcode_q;
    mode_nx       = mode_q;
    col_start_nx  = col_start_q;
    col_end_nx    = col_end_q;
    page_start_nx = page_start_q;
    page_end_nx   = page_end_q;
    disp_nx       = disp_q;
    inv_nx        = inv_q;
    contrast_nx   = contrast_q;
`endif
    if (byte_valid) begin
      if (byte_dc) begin
`ifdef OLED_CMD_DECODE_EN
        state_nx = S_IDLE;
`endif
        we_nx   = 1'b1;
        addr_nx = {page_ptr, col_ptr};
        data_nx = byte_data;
        case (mode_q)
          MODE_VERT: begin
            if (page_ptr == page_end_q) begin
              page_nx = page_start_q;
              if (col_ptr == col_end_q) begin
                col_nx  = col_start_q;
                done_nx = 1'b1;
              end else begin
                col_nx = col_ptr + 7'd1;
              end
            end else begin
              page_nx = page_ptr + 3'd1;
            end
          end
          MODE_PAGE: begin
            col_nx = (col_ptr == col_end_q) ? col_start_q : col_ptr + 7'd1;
          end
          default: begin
            if (col_ptr == col_end_q) begin
              col_nx = col_start_q;
              if (page_ptr == page_end_q) begin
                page_nx = page_start_q;
                done_nx = 1'b1;
              end else begin
                page_nx = page_ptr + 3'd1;
              end
            end else begin
              col_nx = col_ptr + 7'd1;
            end
          end
        endcase
      end else begin
`ifdef OLED_CMD_DECODE_EN
        case (state_q)
          S_IDLE: begin
            opcode_nx = byte_data;
            casez (byte_data)
              8'h20, 8'h21, 8'h22, 8'h81, 8'hA8, 8'hD3,
              8'hD5, 8'hD9, 8'hDA, 8'hDB, 8'h8D: state_nx = S_ARG1;
              8'hAE: disp_nx = 1'b0;
              8'hAF: disp_nx = 1'b1;
              8'hA6: inv_nx  = 1'b0;
              8'hA7: inv_nx  = 1'b1;
              8'b1011_0???: page_nx = byte_data[2:0];
              8'b0000_????: col_nx  = {col_ptr[6:4], byte_data[3:0]};
              8'b0001_0???: col_nx  = {byte_data[2:0], col_ptr[3:0]};
              default: ;
            endcase
          end
          S_ARG1: begin
            state_nx = S_IDLE;
            case (opcode_q)
              8'h20: begin
                if (byte_data[1:0] != 2'b11) mode_nx = addr_mode_e'(byte_data[1:0]);
              end
              8'h21: begin
                col_start_nx = byte_data[6:0];
                state_nx     = S_ARG2;
              end
              8'h22: begin
                page_start_nx = byte_data[2:0];
                state_nx      = S_ARG2;
              end
              8'h81: contrast_nx = byte_data;
              default: ;
            endcase
          end
          S_ARG2: begin
            state_nx = S_IDLE;
            if (opcode_q == 8'h21) begin
              col_end_nx = byte_data[6:0];
              col_nx     = col_start_q;
            end else if (opcode_q == 8'h22) begin
              page_end_nx = byte_data[2:0];
              page_nx     = page_start_q;
            end
          end
          default: state_nx = S_IDLE;
        endcase
`else
        col_nx  = '0;
        page_nx = '0;
`endif
      end
    end
  end

  // Register pointers, write outputs and command state from the decode cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_ptr    <= '0;
      page_ptr   <= '0;
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_data    <= '0;
      frame_done <= 1'b0;
`ifdef OLED_CMD_DECODE_EN
      state_q      <= S_IDLE;
      opcode_q     <= '0;
      mode_q       <= MODE_PAGE;
      col_start_q  <= 7'd0;
      col_end_q    <= 7'd127;
      page_start_q <= 3'd0;
      page_end_q   <= 3'd7;
      disp_q       <= 1'b0;
      inv_q        <= 1'b0;
      contrast_q   <= 8'h7F;
`endif
    end else begin
      col_ptr    <= col_nx;
      page_ptr   <= page_nx;
      fb_we      <= we_nx;
      fb_addr    <= addr_nx;
      fb_data    <= data_nx;
      frame_done <= done_nx;
`ifdef OLED_CMD_DECODE_EN
      state_q      <= state_nx;
      opcode_q     <= opcode_nx;
      mode_q       <= mode_nx;
      col_start_q  <= col_start_nx;
      col_end_q    <= col_end_nx;
      page_start_q <= page_start_nx;
      page_end_q   <= page_end_nx;
      disp_q       <= disp_nx;
      inv_q        <= inv_nx;
      contrast_q   <= contrast_nx;
`endif
    end
  end

endmodule

// File: tb/tb_ssd1306_spi_decoder.sv
// tb_ssd1306_spi_decoder: directed and randomized SPI traffic for ssd1306_spi_decoder,
// checked against a behavioural display-controller model kept in this bench.
module tb_ssd1306_spi_decoder;

  localparam int SYNC_STAGES = 2;
`ifdef OLED_CMD_DECODE_EN
  localparam bit DECODE = 1'b1;
`else
  localparam bit DECODE = 1'b0;
`endif

  typedef struct packed {
    logic [9:0] addr;
    logic [7:0] data;
    logic       done;
    int         cyc;
  } wr_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       oled_sck = 1'b0;
  logic       oled_mosi = 1'b0;
  logic       oled_dc = 1'b0;
  logic       oled_cs_n = 1'b1;
  logic       fb_we;
  logic [9:0] fb_addr;
  logic [7:0] fb_data;
  logic       frame_done;
  logic       display_on;
  logic       invert;
  logic [7:0] contrast;

  int  checks = 0;
  int  failures = 0;
  int  cycle_cnt = 0;
  int  last_rise = 0;
  wr_t obs_q[$];
  wr_t exp_q[$];

  // Reference model state, in plain display-controller terms
  int       m_mode;
  int       m_cs, m_ce, m_ps, m_pe, m_col, m_page;
  int       m_pend, m_argn;
  logic [7:0] m_op;
  bit       m_disp, m_inv;
  logic [7:0] m_contrast;

  ssd1306_spi_decoder #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clock      (clock),
    .reset      (reset),
    .oled_sck   (oled_sck),
    .oled_mosi  (oled_mosi),
    .oled_dc    (oled_dc),
    .oled_cs_n  (oled_cs_n),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .frame_done (frame_done),
    .display_on (display_on),
    .invert     (invert),
    .contrast   (contrast)
  );

  // Free-running system clock
  always #5 clock = ~clock;

  // Cycle counter used to check end-to-end write latency
  always @(posedge clock) cycle_cnt++;

  // Capture every write or frame_done pulse, sampled mid-cycle
  always @(negedge clock) begin
    wr_t w;
    if (reset && (fb_we || frame_done)) begin
      w.addr = fb_addr;
      w.data = fb_data;
      w.done = frame_done;
      w.cyc  = cycle_cnt;
      obs_q.push_back(w);
    end
  end

  function automatic void model_reset();
    m_mode = DECODE ? 2 : 0;
    m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 7;
    m_col = 0; m_page = 0;
    m_pend = 0; m_argn = 0; m_op = 8'h00;
    m_disp = DECODE ? 1'b0 : 1'b1;
    m_inv = 1'b0;
    m_contrast = 8'h7F;
  endfunction

  function automatic void model_byte(bit dc, logic [7:0] b);
    wr_t w;
    if (dc) begin
      m_pend = 0;
      w.addr = 10'(m_page * 128 + m_col);
      w.data = b;
      w.done = 1'b0;
      w.cyc  = last_rise + SYNC_STAGES + 2;
      if (m_mode == 1) begin
        if (m_page == m_pe) begin
          m_page = m_ps;
          if (m_col == m_ce) begin m_col = m_cs; w.done = 1'b1; end
          else m_col = (m_col + 1) % 128;
        end else m_page = (m_page + 1) % 8;
      end else if (m_mode == 2) begin
        m_col = (m_col == m_ce) ? m_cs : (m_col + 1) % 128;
      end else begin
        if (m_col == m_ce) begin
          m_col = m_cs;
          if (m_page == m_pe) begin m_page = m_ps; w.done = 1'b1; end
          else m_page = (m_page + 1) % 8;
        end else m_col = (m_col + 1) % 128;
      end
      exp_q.push_back(w);
    end else if (!DECODE) begin
      m_col = 0;
      m_page = 0;
    end else if (m_pend > 0) begin
      m_pend--;
      m_argn++;
      case (m_op)
        8'h20: if (b % 4 != 3) m_mode = b % 4;
        8'h21: if (m_argn == 1) m_cs = b % 128; else begin m_ce = b % 128; m_col = m_cs; end
        8'h22: if (m_argn == 1) m_ps = b % 8; else begin m_pe = b % 8; m_page = m_ps; end
        8'h81: m_contrast = b;
        default: ;
      endcase
    end else begin
      m_op = b;
      m_argn = 0;
      if (b == 8'h21 || b == 8'h22) m_pend = 2;
      else if (b == 8'h20 || b == 8'h81 || b == 8'hA8 || b == 8'hD3 || b == 8'hD5 ||
               b == 8'hD9 || b == 8'hDA || b == 8'hDB || b == 8'h8D) m_pend = 1;
      else if (b == 8'hAE) m_disp = 1'b0;
      else if (b == 8'hAF) m_disp = 1'b1;
      else if (b == 8'hA6) m_inv = 1'b0;
      else if (b == 8'hA7) m_inv = 1'b1;
      else if (b >= 8'hB0 && b <= 8'hB7) m_page = b - 8'hB0;
      else if (b <= 8'h0F) m_col = (m_col / 16) * 16 + b;
      else if (b >= 8'h10 && b <= 8'h17) m_col = (b - 8'h10) * 16 + m_col % 16;
    end
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One SPI bit: mosi changes with the sck fall, 3 clocks low, 3 clocks high
  task automatic spi_bit(input bit v);
    oled_mosi = v;
    repeat (3) @(negedge clock);
    oled_sck = 1'b1;
    last_rise = cycle_cnt;
    repeat (3) @(negedge clock);
    oled_sck = 1'b0;
  endtask

  task automatic apply_stimulus(input bit dc, input logic [7:0] b);
    if (oled_cs_n) begin
      oled_cs_n = 1'b0;
      repeat (3) @(negedge clock);
    end
    oled_dc = dc;
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
    model_byte(dc, b);
  endtask

  task automatic check_writes(input string tag);
    int n;
    repeat (8) @(negedge clock);
    check_output({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_output(tag, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_status(input string tag);
    check_output({tag, "_display_on"}, 64'(display_on), 64'(m_disp));
    check_output({tag, "_invert"}, 64'(invert), 64'(m_inv));
    check_output({tag, "_contrast"}, 64'(contrast), 64'(m_contrast));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_fb_we"}, 64'(fb_we), 64'(0));
    check_output({tag, "_fb_addr"}, 64'(fb_addr), 64'(0));
    check_output({tag, "_fb_data"}, 64'(fb_data), 64'(0));
    check_output({tag, "_frame_done"}, 64'(frame_done), 64'(0));
    check_status(tag);
  endtask

  initial begin
    logic [7:0] r;
    model_reset();
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    $display("[TB] reset state");
    check_reset_outputs("reset");

    $display("[TB] full horizontal frame");
    apply_stimulus(1'b0, 8'h20);
    apply_stimulus(1'b0, 8'h00);
    for (int i = 0; i < 1024; i++) apply_stimulus(1'b1, 8'(i));
    check_writes("frame");

    $display("[TB] windowed horizontal");
    apply_stimulus(1'b0, 8'h21); apply_stimulus(1'b0, 8'h10); apply_stimulus(1'b0, 8'h11);
    apply_stimulus(1'b0, 8'h22); apply_stimulus(1'b0, 8'h02); apply_stimulus(1'b0, 8'h03);
    apply_stimulus(1'b0, 8'h20); apply_stimulus(1'b0, 8'h00);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 8'($urandom));
    check_writes("window");

    $display("[TB] vertical mode");
    apply_stimulus(1'b0, 8'h21); apply_stimulus(1'b0, 8'h00); apply_stimulus(1'b0, 8'h7F);
    apply_stimulus(1'b0, 8'h22); apply_stimulus(1'b0, 8'h00); apply_stimulus(1'b0, 8'h07);
    apply_stimulus(1'b0, 8'h20); apply_stimulus(1'b0, 8'h01);
    apply_stimulus(1'b0, 8'hB0); apply_stimulus(1'b0, 8'h00); apply_stimulus(1'b0, 8'h10);
    for (int i = 0; i < 9; i++) apply_stimulus(1'b1, 8'($urandom));
    check_writes("vertical");

    $display("[TB] data aborts pending contrast");
    apply_stimulus(1'b0, 8'h81);
    apply_stimulus(1'b1, 8'h55);
    apply_stimulus(1'b0, 8'hA7);
    apply_stimulus(1'b1, 8'($urandom));
    check_writes("abort");
    check_status("abort");

    $display("[TB] partial byte discarded on deselect");
    oled_cs_n = 1'b0;
    repeat (3) @(negedge clock);
    oled_dc = 1'b1;
    for (int i = 0; i < 5; i++) spi_bit(1'($urandom));
    oled_cs_n = 1'b1;
    repeat (6) @(negedge clock);
    apply_stimulus(1'b0, 8'hAF);
    check_writes("partial");
    check_status("partial");

    $display("[TB] randomized traffic");
    for (int k = 0; k < 120; k++) begin
      if ($urandom_range(0, 9) < 6) begin
        apply_stimulus(1'b1, 8'($urandom));
      end else begin
        case ($urandom_range(0, 9))
          0: apply_stimulus(1'b0, 8'hAE + 8'($urandom_range(0, 1)));
          1: apply_stimulus(1'b0, 8'hA6 + 8'($urandom_range(0, 1)));
          2: begin apply_stimulus(1'b0, 8'h81); apply_stimulus(1'b0, 8'($urandom)); end
          3: begin apply_stimulus(1'b0, 8'h20); apply_stimulus(1'b0, 8'($urandom_range(0, 3))); end
          4: begin
            apply_stimulus(1'b0, 8'h21);
            apply_stimulus(1'b0, 8'($urandom));
            apply_stimulus(1'b0, 8'($urandom));
          end
          5: begin
            apply_stimulus(1'b0, 8'h22);
            apply_stimulus(1'b0, 8'($urandom));
            apply_stimulus(1'b0, 8'($urandom));
          end
          6: apply_stimulus(1'b0, 8'hB0 + 8'($urandom_range(0, 7)));
          7: apply_stimulus(1'b0, 8'($urandom_range(0, 15)));
          8: apply_stimulus(1'b0, 8'h10 + 8'($urandom_range(0, 7)));
          default: begin r = 8'($urandom); apply_stimulus(1'b0, r); end
        endcase
      end
    end
    check_writes("random");
    check_status("random");

    $display("[TB] reset mid-byte");
    apply_stimulus(1'b0, 8'hB3);
    apply_stimulus(1'b1, 8'h5A);
    apply_stimulus(1'b1, 8'hC3);
    check_writes("prereset");
    oled_dc = 1'b1;
    for (int i = 0; i < 4; i++) spi_bit(1'b1);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("async_reset");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    obs_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clock);
    apply_stimulus(1'b1, 8'hA5);
    check_writes("postreset");
    check_output("postreset_addr_value", 64'(fb_addr), 64'(0));
    check_output("postreset_data_value", 64'(fb_data), 64'(8'hA5));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ssd1306_spi_decoder.md
# ssd1306_spi_decoder

Front end of the Arduboy display path: receives the core's SSD1306-style SPI stream, deserializes bytes, decodes display commands, and turns data bytes into addressed framebuffer writes. The framebuffer is 1 KiB, 8 pages × 128 columns, one byte per column per page. The VGA/HDMI scan-out stage downstream reads that framebuffer. The block also exports display on/off, invert and contrast state for the scan-out stage.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer flops on each SPI input (≥2).

Ports:
- clock  in  1  system clock; all logic in this domain
- reset  in  1  asynchronous, active-low reset
- oled_sck  in  1  SPI clock, mode 0, async to clock
- oled_mosi  in  1  SPI data, MSB first
- oled_dc  in  1  1 = data byte, 0 = command byte
- oled_cs_n  in  1  chip select, active low
- fb_we  out  1  one-cycle framebuffer write strobe
- fb_addr  out  10  page*128 + column
- fb_data  out  8  byte to write; bit0 = top row of page
- frame_done  out  1  one-cycle pulse on the write that wraps the window
- display_on  out  1  0xAF sets, 0xAE clears
- invert  out  1  0xA7 sets, 0xA6 clears
- contrast  out  8  last 0x81 argument

## Operation
- Inputs pass through SYNC_STAGES flops. An sck rising edge is detected when the synchronized level is 1 and its one-cycle-delayed copy is 0.
- Each edge with cs_n low shifts mosi into an 8-bit register and increments a 3-bit counter.
- When cs_n is high, the counter is held at 0 and a partial byte is discarded. Command FSM state and pointers are retained.
- On the 8th edge, the byte completes and dc is latched with it.
- Command FSM states:
  - IDLE
  - ARG1
  - ARG2
  - Pending opcode is held in a register.
- Commands handled in IDLE:
  - 0x20: goes to ARG1. arg[1:0] sets the addressing mode: 00 horizontal, 01 vertical, 10 page. Value 11 is ignored.
  - 0x21: ARG1 sets col_start, ARG2 sets col_end (7 bits each). Column pointer is then set to col_start.
  - 0x22: ARG1 sets page_start, ARG2 sets page_end (3 bits each). Page pointer is then set to page_start.
  - 0x81: ARG1 sets contrast.
  - 0xA8, 0xD3, 0xD5, 0xD9, 0xDA, 0xDB, 0x8D: one argument, swallowed.
  - 0xAE/0xAF and 0xA6/0xA7: as listed in Interface.
  - 0xB0–0xB7: page pointer = byte[2:0].
  - 0x00–0x0F: column[3:0] = nibble.
  - 0x10–0x17: column[6:4] = byte[2:0].
  - All other opcodes: no operation, stay in IDLE.
- A data byte arriving in ARG1/ARG2 aborts the pending command, returns the FSM to IDLE, and is processed as data.
- Data byte: write to the current (page, column), then advance the pointer:
  - Horizontal: column++. At col_end, column = col_start and page++. At page_end, page = page_start and frame_done fires.
  - Vertical: page++. At page_end, page = page_start and column++. At col_end, column = col_start and frame_done fires.
  - Page: column++. At col_end, column = col_start. Page is unchanged. frame_done never fires.
- If the pointer is outside the window (start > end, or pointer set past end), it increments modulo field width (128 columns / 8 pages) until it equals the end value. Writes still occur at the actual pointer.

## Timing
- Reset values:
  - fb_we = 0, fb_addr = 0, fb_data = 0, frame_done = 0
  - display_on = 0, invert = 0, contrast = 0x7F
  - Addressing mode = page; column = page = 0; col window 0..127; page window 0..7
  - FSM in IDLE; bit counter 0
- Latency: the cycle after the synchronized sck edge that completes a byte is the decode cycle. fb_we/fb_addr/fb_data/frame_done are registered and valid the following cycle.
- Total latency: SYNC_STAGES+2 clocks from the raw sck rise.
- Command effects (including status outputs) are visible on the same cycle fb_we would have been.
- The pointer advance is visible in fb_addr on the next write.
- Input requirement: sck high and low phases each ≥ SYNC_STAGES+1 clock periods. mosi/dc stable ≥ 1 clock before and after the sck rise (synchronized view). Behaviour outside these limits is undefined but must not lock up.
- A reset assertion mid-byte or mid-command immediately returns all state to reset values.

## Configuration
- OLED_CMD_DECODE_EN defined: full command decoding as above.
- OLED_CMD_DECODE_EN undefined:
  - Every command byte sets column = page = 0 and is otherwise ignored; the FSM does not exist.
  - Mode is fixed horizontal, window fixed at 0..127 / 0..7.
  - display_on is tied to 1, invert to 0, contrast to 0x7F.
  - Data behaviour and timing are unchanged.

## Test plan
- Reset, then send 0x20 0x00 followed by 1024 data bytes 0x00..0xFF repeating -> fb_addr steps 0..1023 in order; fb_data matches; single frame_done on the 1024th write with fb_addr = 1023.
- 0x21 0x10 0x11, 0x22 0x02 0x03, horizontal mode, 5 data bytes -> addresses 272, 273, 400, 401, 272; frame_done on the 4th write.
- 0x20 0x01 (vertical), 9 data bytes -> addresses 0, 128, …, 896, then 1.
- 0x81 then a data byte 0x55 -> contrast stays 0x7F; write of 0x55 at the current pointer; FSM back in IDLE.
- cs_n deasserted after 5 bits, then reasserted and a full 0xAF sent -> display_on = 1; no write; no stray byte.
- Reset asserted mid-byte during a data stream -> all outputs return to reset values asynchronously; the next full byte decodes correctly.
